// File: rtl/gmem_rd_arbiter.sv
// gmem_rd_arbiter: round-robin N-channel AXI4 read arbiter with ID-routed R beats, outstanding limits and sticky errors
module gmem_rd_arbiter #(
  parameter int NUM_CH          = 4,
  parameter int ADDR_WIDTH      = 42,
  parameter int DATA_WIDTH      = 512,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [NUM_CH-1:0]            ch_arvalid,
  output logic [NUM_CH-1:0]            ch_arready,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_araddr,
  input  logic [NUM_CH*8-1:0]          ch_arlen,
  output logic [NUM_CH-1:0]            ch_rvalid,
  input  logic [NUM_CH-1:0]            ch_rready,
  output logic [DATA_WIDTH-1:0]        ch_rdata,
  output logic                         ch_rlast,
  output logic [NUM_CH-1:0]            ch_err,
  output logic                         m_axi_gmem_ARVALID,
  input  logic                         m_axi_gmem_ARREADY,
  output logic [ADDR_WIDTH-1:0]        m_axi_gmem_ARADDR,
  output logic [ID_WIDTH-1:0]          m_axi_gmem_ARID,
  output logic [7:0]                   m_axi_gmem_ARLEN,
  output logic [2:0]                   m_axi_gmem_ARSIZE,
  output logic [1:0]                   m_axi_gmem_ARBURST,
  input  logic                         m_axi_gmem_RVALID,
  output logic                         m_axi_gmem_RREADY,
  input  logic [DATA_WIDTH-1:0]        m_axi_gmem_RDATA,
  input  logic                         m_axi_gmem_RLAST,
  input  logic [ID_WIDTH-1:0]          m_axi_gmem_RID,
  input  logic [1:0]                   m_axi_gmem_RRESP
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] ptr, win, idx, rid_idx;
  logic [NUM_CH-1:0] elig;
  logic [7:0] cnt [NUM_CH];
  logic found, grant, rid_ok, hs, dec;
  assign m_axi_gmem_ARSIZE  = 3'($clog2(DATA_WIDTH/8));
  assign m_axi_gmem_ARBURST = 2'b01;
  assign m_axi_gmem_ARVALID = state == HOLD;
  assign ch_rdata = m_axi_gmem_RDATA;
  assign ch_rlast = m_axi_gmem_RLAST;
  assign rid_ok   = int'(m_axi_gmem_RID) < NUM_CH;
  assign rid_idx  = CW'(m_axi_gmem_RID);
  assign ch_rvalid = rid_ok && m_axi_gmem_RVALID ? NUM_CH'(1) << rid_idx : '0;
  assign m_axi_gmem_RREADY = rid_ok ? ch_rready[rid_idx] : 1'b1;
  assign hs  = m_axi_gmem_RVALID && m_axi_gmem_RREADY;
  assign dec = hs && rid_ok && m_axi_gmem_RLAST && cnt[rid_idx] != 8'd0;
  // a channel may compete only while below its outstanding-burst limit
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CH; i++) elig[i] = ch_arvalid[i] && cnt[i] < 8'(MAX_OUTSTANDING);
  end
  // round-robin search starting just after the last winner
  always_comb begin
    found = 1'b0;
    win = ptr;
    idx = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CW'((int'(ptr) + k) % NUM_CH);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  // a new grant is possible when no AR is pending or the pending one is being accepted
  always_comb begin
    grant = !ap_rst && found && (state == IDLE || m_axi_gmem_ARREADY);
    ch_arready = grant ? NUM_CH'(1) << win : '0;
    state_nxt = grant || (state == HOLD && !m_axi_gmem_ARREADY) ? HOLD : IDLE;
  end
  // AR state, pointer and registered AR fields of the granted channel
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= IDLE;
      ptr <= CW'(NUM_CH - 1);
      m_axi_gmem_ARADDR <= '0;
      m_axi_gmem_ARLEN <= '0;
      m_axi_gmem_ARID <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        ptr <= win;
        m_axi_gmem_ARADDR <= ch_araddr[win*ADDR_WIDTH +: ADDR_WIDTH];
        m_axi_gmem_ARLEN <= ch_arlen[win*8 +: 8];
        m_axi_gmem_ARID <= ID_WIDTH'(win);
      end
    end
  end
  // per-channel bursts in flight: +1 on grant, -1 on last beat, never below zero
  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < NUM_CH; i++)
      cnt[i] <= ap_rst ? 8'd0 : cnt[i] + 8'(grant && win == CW'(i)) - 8'(dec && rid_idx == CW'(i));
  end
  // sticky errors: unknown RID flags everyone, bad RRESP or stray RLAST flags the owner
  always_ff @(posedge ap_clk) begin
    if (ap_rst) ch_err <= '0;
    else if (hs && !rid_ok) ch_err <= '1;
    else if (hs && (m_axi_gmem_RRESP != 2'b00 || (m_axi_gmem_RLAST && cnt[rid_idx] == 8'd0))) ch_err[rid_idx] <= 1'b1;
  end
endmodule

// File: tb/tb_gmem_rd_arbiter.sv
// tb_gmem_rd_arbiter: scoreboard bench for the round-robin read arbiter
module tb_gmem_rd_arbiter;
  localparam int N = 4, AW = 42, DW = 64, IW = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [N-1:0] ch_arvalid, ch_arready, ch_rvalid, ch_rready, ch_err;
  logic [N*AW-1:0] ch_araddr;
  logic [N*8-1:0] ch_arlen;
  logic [DW-1:0] ch_rdata;
  logic ch_rlast;
  logic ar_valid, ar_ready;
  logic [AW-1:0] ar_addr;
  logic [IW-1:0] ar_id;
  logic [7:0] ar_len;
  logic [2:0] ar_size;
  logic [1:0] ar_burst;
  logic r_valid, r_ready, r_last;
  logic [DW-1:0] r_data;
  logic [IW-1:0] r_id;
  logic [1:0] r_resp;
  typedef struct {logic [AW-1:0] addr; logic [7:0] len; logic [IW-1:0] id;} ar_t;
  typedef struct {logic [N-1:0] v; logic rdy; logic [DW-1:0] d; logic l;} r_t;
  ar_t arq[$];
  r_t rq[$];
  ar_t ae;
  r_t re;
  int total = 0, bad = 0;

  gmem_rd_arbiter #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(2)) dut (
    .ap_clk(clk), .ap_rst(rst),
    .ch_arvalid(ch_arvalid), .ch_arready(ch_arready), .ch_araddr(ch_araddr), .ch_arlen(ch_arlen),
    .ch_rvalid(ch_rvalid), .ch_rready(ch_rready), .ch_rdata(ch_rdata), .ch_rlast(ch_rlast), .ch_err(ch_err),
    .m_axi_gmem_ARVALID(ar_valid), .m_axi_gmem_ARREADY(ar_ready), .m_axi_gmem_ARADDR(ar_addr),
    .m_axi_gmem_ARID(ar_id), .m_axi_gmem_ARLEN(ar_len), .m_axi_gmem_ARSIZE(ar_size), .m_axi_gmem_ARBURST(ar_burst),
    .m_axi_gmem_RVALID(r_valid), .m_axi_gmem_RREADY(r_ready), .m_axi_gmem_RDATA(r_data),
    .m_axi_gmem_RLAST(r_last), .m_axi_gmem_RID(r_id), .m_axi_gmem_RRESP(r_resp)
  );

  always @(negedge clk) begin
    if (!rst && ar_valid && ar_ready) begin
      total++;
      if (arq.size() == 0) begin
        bad++;
        $display("FAIL ar_extra: got id=%0d addr=%h, none expected", ar_id, ar_addr);
      end else begin
        ae = arq.pop_front();
        if (ar_addr !== ae.addr || ar_len !== ae.len || ar_id !== ae.id) begin
          bad++;
          $display("FAIL ar_fields: got addr=%h len=%0d id=%0d want addr=%h len=%0d id=%0d", ar_addr, ar_len, ar_id, ae.addr, ae.len, ae.id);
        end
      end
    end
    if (!rst && r_valid) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL r_extra: got rid=%0d, none expected", r_id);
      end else begin
        re = rq.pop_front();
        if (ch_rvalid !== re.v || r_ready !== re.rdy || (re.v != 0 && (ch_rdata !== re.d || ch_rlast !== re.l))) begin
          bad++;
          $display("FAIL r_route: got v=%b rdy=%b d=%h l=%b want v=%b rdy=%b d=%h l=%b", ch_rvalid, r_ready, ch_rdata, ch_rlast, re.v, re.rdy, re.d, re.l);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    ch_arvalid = '0;
    ar_ready = 1'b0;
    r_valid = 1'b0;
    ch_rready = '1;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic set_req(input int c, input logic [AW-1:0] a, input logic [7:0] l);
    ch_arvalid[c] = 1'b1;
    ch_araddr[c*AW +: AW] = a;
    ch_arlen[c*8 +: 8] = l;
  endtask

  task automatic exp_ar(input int c);
    ar_t e;
    e.addr = ch_araddr[c*AW +: AW];
    e.len = ch_arlen[c*8 +: 8];
    e.id = IW'(c);
    arq.push_back(e);
  endtask

  task automatic r_drive(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic l, input logic [1:0] resp, input logic [N-1:0] rdy);
    r_t e;
    r_valid = 1'b1;
    r_id = id;
    r_data = d;
    r_last = l;
    r_resp = resp;
    ch_rready = rdy;
    e.d = d;
    e.l = l;
    if (int'(id) < N) begin
      e.v = N'(1) << id;
      e.rdy = rdy[id[1:0]];
    end else begin
      e.v = '0;
      e.rdy = 1'b1;
    end
    rq.push_back(e);
  endtask

  task automatic beat(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic l, input logic [1:0] resp, input logic [N-1:0] rdy);
    r_drive(id, d, l, resp, rdy);
    step;
    r_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ch_arvalid = '1;
    ch_araddr = '1;
    ch_arlen = '1;
    ch_rready = '1;
    ar_ready = 1'b1;
    r_valid = 1'b0;
    r_id = '0;
    r_data = '0;
    r_last = 1'b0;
    r_resp = '0;
    step;
    step;
    @(negedge clk);
    total++;
    if (ar_valid !== 1'b0 || ar_addr !== '0 || ar_len !== '0 || ar_id !== '0) begin
      bad++;
      $display("FAIL reset_ar: got v=%b a=%h l=%h id=%h want all zero", ar_valid, ar_addr, ar_len, ar_id);
    end
    total++;
    if (ch_arready !== '0 || ch_err !== '0) begin
      bad++;
      $display("FAIL reset_ch: got arready=%b err=%b want 0000 0000", ch_arready, ch_err);
    end
    total++;
    if (ar_size !== 3'd3 || ar_burst !== 2'b01) begin
      bad++;
      $display("FAIL const_fields: got size=%0d burst=%b want 3 01", ar_size, ar_burst);
    end
    step;
    ch_arvalid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single;
    do_reset;
    ar_ready = 1'b1;
    set_req(0, AW'(32'h1000), 8'd3);
    @(negedge clk);
    total++;
    if (ch_arready !== 4'b0001) begin
      bad++;
      $display("FAIL single_grant: got %b want 0001", ch_arready);
    end
    exp_ar(0);
    step;
    ch_arvalid = '0;
    @(negedge clk);
    total++;
    if (ch_arready !== 4'b0000 || ar_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_hold: got arready=%b arvalid=%b want 0000 1", ch_arready, ar_valid);
    end
    step;
    beat(0, 64'hA0, 1'b0, 2'b00, 4'b1110);
    for (int i = 0; i < 4; i++) beat(0, 64'hA0 + 64'(i), i == 3, 2'b00, 4'b1111);
    @(negedge clk);
    total++;
    if (ch_err !== 4'b0000) begin
      bad++;
      $display("FAIL single_noerr: got %b want 0000", ch_err);
    end
    step;
    beat(0, 64'hBAD, 1'b1, 2'b00, 4'b1111);
    @(negedge clk);
    total++;
    if (ch_err !== 4'b0001) begin
      bad++;
      $display("FAIL stray_rlast: got %b want 0001", ch_err);
    end
    step;
  endtask

  task automatic test_round_robin;
    do_reset;
    ar_ready = 1'b1;
    for (int c = 0; c < N; c++) set_req(c, AW'(32'h2000 + c*256), 8'(c + 1));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (ch_arready !== N'(1) << (i % N) || (i > 0 && ar_valid !== 1'b1)) begin
        bad++;
        $display("FAIL rr_grant%0d: got arready=%b arvalid=%b want %b 1", i, ch_arready, ar_valid, N'(1) << (i % N));
      end
      exp_ar(i % N);
      step;
    end
    ch_arvalid = '0;
    @(negedge clk);
    step;
    @(negedge clk);
    total++;
    if (ar_valid !== 1'b0) begin
      bad++;
      $display("FAIL rr_idle: got arvalid=%b want 0", ar_valid);
    end
    step;
  endtask

  task automatic test_backpressure;
    do_reset;
    set_req(0, AW'(32'h3000), 8'd7);
    set_req(1, AW'(32'h3100), 8'd5);
    @(negedge clk);
    total++;
    if (ch_arready !== 4'b0001) begin
      bad++;
      $display("FAIL bp_first: got %b want 0001", ch_arready);
    end
    exp_ar(0);
    step;
    ch_arvalid[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (ch_arready !== 4'b0000 || ar_valid !== 1'b1 || ar_addr !== AW'(32'h3000) || ar_len !== 8'd7 || ar_id !== 4'd0) begin
        bad++;
        $display("FAIL bp_hold%0d: got rdy=%b v=%b a=%h l=%0d id=%0d want 0000 1 3000 7 0", i, ch_arready, ar_valid, ar_addr, ar_len, ar_id);
      end
      step;
    end
    ar_ready = 1'b1;
    @(negedge clk);
    total++;
    if (ch_arready !== 4'b0010) begin
      bad++;
      $display("FAIL bp_resume: got %b want 0010", ch_arready);
    end
    exp_ar(1);
    step;
    ch_arvalid = '0;
    @(negedge clk);
    step;
  endtask

  task automatic test_limit;
    do_reset;
    ar_ready = 1'b1;
    set_req(1, AW'(32'h4000), 8'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (ch_arready !== 4'b0010) begin
        bad++;
        $display("FAIL limit_req%0d: got %b want 0010", i, ch_arready);
      end
      exp_ar(1);
      step;
    end
    set_req(2, AW'(32'h4200), 8'd2);
    @(negedge clk);
    total++;
    if (ch_arready !== 4'b0100) begin
      bad++;
      $display("FAIL limit_skip: got %b want 0100", ch_arready);
    end
    exp_ar(2);
    step;
    ch_arvalid[2] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (ch_arready !== 4'b0000) begin
        bad++;
        $display("FAIL limit_block%0d: got %b want 0000", i, ch_arready);
      end
      step;
    end
    beat(1, 64'h55, 1'b1, 2'b00, 4'b1111);
    @(negedge clk);
    total++;
    if (ch_arready !== 4'b0010) begin
      bad++;
      $display("FAIL limit_release: got %b want 0010", ch_arready);
    end
    exp_ar(1);
    step;
    ch_arvalid = '0;
    @(negedge clk);
    step;
  endtask

  task automatic test_simultaneous;
    do_reset;
    ar_ready = 1'b1;
    set_req(0, AW'(32'h5000), 8'd0);
    @(negedge clk);
    exp_ar(0);
    step;
    ch_arvalid[0] = 1'b0;
    @(negedge clk);
    step;
    ch_arvalid[0] = 1'b1;
    r_drive(0, 64'h77, 1'b1, 2'b00, 4'b1111);
    @(negedge clk);
    total++;
    if (ch_arready !== 4'b0001) begin
      bad++;
      $display("FAIL sim_grant: got %b want 0001", ch_arready);
    end
    exp_ar(0);
    step;
    r_valid = 1'b0;
    @(negedge clk);
    total++;
    if (ch_arready !== 4'b0001) begin
      bad++;
      $display("FAIL sim_cnt_one: got %b want 0001", ch_arready);
    end
    exp_ar(0);
    step;
    @(negedge clk);
    total++;
    if (ch_arready !== 4'b0000 || ch_err !== 4'b0000) begin
      bad++;
      $display("FAIL sim_cnt_full: got arready=%b err=%b want 0000 0000", ch_arready, ch_err);
    end
    step;
    ch_arvalid = '0;
    step;
  endtask

  task automatic test_errors;
    do_reset;
    beat(2, 64'h1, 1'b0, 2'b10, 4'b1111);
    @(negedge clk);
    total++;
    if (ch_err !== 4'b0100) begin
      bad++;
      $display("FAIL err_resp: got %b want 0100", ch_err);
    end
    step;
    step;
    @(negedge clk);
    total++;
    if (ch_err !== 4'b0100) begin
      bad++;
      $display("FAIL err_sticky: got %b want 0100", ch_err);
    end
    step;
    beat(7, 64'h2, 1'b1, 2'b00, 4'b0000);
    @(negedge clk);
    total++;
    if (ch_err !== 4'b1111) begin
      bad++;
      $display("FAIL err_badid: got %b want 1111", ch_err);
    end
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (ch_err !== 4'b0000) begin
      bad++;
      $display("FAIL err_clear: got %b want 0000", ch_err);
    end
    step;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_limit;
    test_simultaneous;
    test_errors;
    total++;
    if (arq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got ar=%0d r=%0d pending want 0 0", arq.size(), rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
